xor_frame_rx: RTL and testbench

Receive-side checker for the nibble-stream XOR-checksum framing used by our XOR/parity test infrastructure. Accepts length-prefixed frames over a valid/ready input, forwards payload nibbles downstream with backpressure, recomputes the running XOR of the payload and compares it against the trailing check nibble. Sits at the far end of the XOR frame transmitter and reports a per-frame pass/fail status.

---
 rtl/xor_frame_pkg.sv | 13 +
 rtl/xor_frame_outreg.sv | 47 ++++
 rtl/xor_frame_rx.sv | 158 +++++++++++++++
 tb/tb_xor_frame_rx.sv | 510 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_frame_pkg.sv
// Shared definitions for the XOR-checksum nibble framing (transmitter and receiver).
package xor_frame_pkg;

    localparam int XOR_FRAME_DATA_W = 4;   // default nibble width
    localparam int XOR_FRAME_CNT_W  = 8;   // width of the failed-frame counter

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // waiting for a length beat
        ST_DATA  = 2'd1,   // payload beats outstanding
        ST_CHECK = 2'd2    // waiting for the check nibble
    } frame_state_t;

endpackage

// File: rtl/xor_frame_outreg.sv
// One-entry output register with valid/ready handshake. Holds data/last until the
// downstream accepts and tells the upstream when a new beat may be taken.
module xor_frame_outreg
    import xor_frame_pkg::*;
#(
    parameter int DATA_W = XOR_FRAME_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // Register is free when empty or being drained this cycle; never ready in reset.
    assign o_ready = rst_n && (i_ready || !r_valid);

    // Load a new beat when free, otherwise clear valid once the downstream takes it.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/xor_frame_rx.sv
// Receive-side checker for length-prefixed nibble frames with a trailing XOR check.
// Forwards payload downstream and pulses frame_done/frame_ok when each frame closes.
// Optional failed-frame counter: define XOR_FRAME_RX_STATS_EN to build it;
// otherwise err_count is tied to zero.
module xor_frame_rx
    import xor_frame_pkg::*;
#(
    parameter int DATA_W  = XOR_FRAME_DATA_W,
    parameter int MAX_LEN = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    input  logic                       out_ready,
    output logic                       frame_done,
    output logic                       frame_ok,
    output logic [XOR_FRAME_CNT_W-1:0] err_count
);

    localparam int CNT_W = XOR_FRAME_CNT_W;

    frame_state_t      r_state, w_state_nxt;
    logic [DATA_W-1:0] r_acc, w_acc_nxt;
    logic [DATA_W-1:0] r_remaining, w_rem_nxt;
    logic              r_frame_done, r_frame_ok;
    logic              r_fail_pend;     // second failure pulse owed (abort + illegal length)

    logic w_in_ready, w_accept;
    logic w_fwd, w_fwd_last;
    logic w_abort, w_len_bad, w_check_beat;
    logic w_done_nxt, w_ok_nxt, w_pend_nxt;

    assign in_ready = w_in_ready;
    assign w_accept = in_valid && w_in_ready;

    // Frame parser: next state, accumulator, remaining count and payload forwarding.
    // NOTE: every always_comb output is defaulted first so no latch can be inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_rem_nxt    = r_remaining;
        w_fwd        = 1'b0;
        w_fwd_last   = 1'b0;
        w_abort      = 1'b0;
        w_len_bad    = 1'b0;
        w_check_beat = 1'b0;
        if (w_accept) begin
            if (in_sof) begin
                // A length beat always starts over; an open frame is aborted.
                w_abort   = (r_state != ST_IDLE);
                w_acc_nxt = '0;
                if (in_data == '0 || int'(in_data) > MAX_LEN) begin
                    w_len_bad   = 1'b1;
                    w_rem_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rem_nxt   = in_data;
                    w_state_nxt = ST_DATA;
                end
            end else begin
                unique case (r_state)
                    ST_DATA: begin
                        w_acc_nxt  = r_acc ^ in_data;
                        w_fwd      = 1'b1;
                        w_fwd_last = (r_remaining == DATA_W'(1));
                        w_rem_nxt  = r_remaining - DATA_W'(1);
                        if (w_fwd_last) begin
                            w_state_nxt = ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        w_check_beat = 1'b1;
                        w_state_nxt  = ST_IDLE;
                    end
                    default: begin
                        // Stray non-length beats outside a frame are dropped.
                    end
                endcase
            end
        end
    end

    // Frame status: failures (owed, abort, illegal length) take precedence; an abort
    // followed by an illegal length owes one more failure pulse on the next cycle.
    always_comb begin
        w_done_nxt = 1'b0;
        w_ok_nxt   = 1'b0;
        w_pend_nxt = 1'b0;
        if (r_fail_pend || w_abort || w_len_bad) begin
            w_done_nxt = 1'b1;
            w_pend_nxt = (r_fail_pend || w_abort) && w_len_bad;
        end else if (w_check_beat) begin
            w_done_nxt = 1'b1;
            w_ok_nxt   = (in_data == r_acc);
        end
    end

    // Parser and status registers; reset discards any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_remaining  <= '0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_fail_pend  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acc        <= w_acc_nxt;
            r_remaining  <= w_rem_nxt;
            r_frame_done <= w_done_nxt;
            r_frame_ok   <= w_ok_nxt;
            r_fail_pend  <= w_pend_nxt;
        end
    end

    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;

`ifdef XOR_FRAME_RX_STATS_EN
    logic [CNT_W-1:0] r_err_count;

    // Saturating count of failed frames, updated on the same edge as frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (w_done_nxt && !w_ok_nxt && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    xor_frame_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_fwd),
        .i_data  (in_data),
        .i_last  (w_fwd_last),
        .o_ready (w_in_ready),
        .o_valid (out_valid),
        .o_data  (out_data),
        .o_last  (out_last),
        .i_ready (out_ready)
    );

endmodule

// File: tb/tb_xor_frame_rx.sv
// Self-checking bench for xor_frame_rx: directed scenarios plus randomized streams,
// scored against a segment-level reference model of the framing rules.
// Honours XOR_FRAME_RX_STATS_EN for the expected err_count.
module tb_xor_frame_rx;

    localparam int DW   = 4;
    localparam int MAXL = 15;

    typedef struct { bit sof; bit [DW-1:0] d; } beat_t;
    typedef struct { logic [DW-1:0] d; logic last; int cyc; } obeat_t;
    typedef struct { logic ok; int cyc; } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, out_last, frame_done, frame_ok;
    logic [DW-1:0] out_data;
    logic [7:0]    err_count;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     fails_since_reset = 0;
    beat_t  stim_q[$];
    int     acc_cyc_q[$];
    obeat_t obs_out_q[$];
    obeat_t exp_out_q[$];
    res_t   obs_res_q[$];
    bit     exp_res_q[$];

    xor_frame_rx #(.DATA_W(DW), .MAX_LEN(MAXL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sample mid-low-phase, after the driver has settled its inputs.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (out_valid && out_ready) obs_out_q.push_back('{out_data, out_last, cyc});
            if (frame_done) obs_res_q.push_back('{frame_ok, cyc});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Reference model: split the accepted stream at length beats; each segment is
    // judged from its length, payload slice and the beat right after the payload.
    function automatic void build_expect();
        int i;
        int j;
        int len;
        int n;
        bit [DW-1:0] x;
        beat_t seg[$];
        exp_out_q.delete();
        exp_res_q.delete();
        n = stim_q.size();
        i = 0;
        while (i < n && !stim_q[i].sof) i++;
        while (i < n) begin
            seg.delete();
            j = i + 1;
            while (j < n && !stim_q[j].sof) begin
                seg.push_back(stim_q[j]);
                j++;
            end
            len = int'(stim_q[i].d);
            x = '0;
            if (len == 0 || len > MAXL) begin
                exp_res_q.push_back(1'b0);
            end else begin
                for (int k = 0; k < len && k < seg.size(); k++) begin
                    x = x ^ seg[k].d;
                    exp_out_q.push_back('{seg[k].d, (k == len - 1), 0});
                end
                if (seg.size() > len) exp_res_q.push_back(seg[len].d == x);
                else if (j < n) exp_res_q.push_back(1'b0);
            end
            i = j;
        end
    endfunction

    function automatic logic [7:0] exp_err();
`ifdef XOR_FRAME_RX_STATS_EN
        return (fails_since_reset > 255) ? 8'd255 : 8'(fails_since_reset);
`else
        return 8'd0;
`endif
    endfunction

    task automatic add(input bit sof, input bit [DW-1:0] d);
        stim_q.push_back('{sof, d});
    endtask

    task automatic drive_beats(input int ready_pct, input int gap_pct);
        int idx = 0;
        int budget = 0;
        acc_cyc_q.delete();
        while (idx < stim_q.size() && budget < 5000) begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < ready_pct);
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_sof   = stim_q[idx].sof;
                in_data  = stim_q[idx].d;
            end
            #1;
            if (in_valid && in_ready) begin
                acc_cyc_q.push_back(cyc);
                idx++;
            end
            budget++;
        end
        checks++;
        if (idx != stim_q.size()) begin
            errors++;
            $display("FAIL drive_timeout: accepted %0d beats, required %0d", idx, stim_q.size());
        end
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    task automatic run_stream(input int ready_pct, input int gap_pct);
        obs_out_q.delete();
        obs_res_q.delete();
        drive_beats(ready_pct, gap_pct);
        drain(6);
        build_expect();
        foreach (exp_res_q[k]) if (!exp_res_q[k]) fails_since_reset++;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, frame_done, frame_ok, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h l=%b done=%b ok=%b err=%0d, required all 0",
                     in_ready, out_valid, out_data, out_last, frame_done, frame_ok, err_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, frame_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held: got rdy=%b v=%b done=%b, required 000", in_ready, out_valid, frame_done);
        end
        rst_n = 1'b1;
        fails_since_reset = 0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_good_frame();
        stim_q.delete();
        add(1, 4'd3); add(0, 4'd1); add(0, 4'd2); add(0, 4'd4); add(0, 4'd7);
        run_stream(100, 0);
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin
            errors++; $display("FAIL good_out_count: got %0d required %0d", obs_out_q.size(), exp_out_q.size());
        end else foreach (exp_out_q[k]) begin
            checks++;
            if ({obs_out_q[k].d, obs_out_q[k].last} !== {exp_out_q[k].d, exp_out_q[k].last}) begin
                errors++; $display("FAIL good_beat%0d: got %h/%b required %h/%b", k,
                                   obs_out_q[k].d, obs_out_q[k].last, exp_out_q[k].d, exp_out_q[k].last);
            end
            checks++;
            if (obs_out_q[k].cyc != acc_cyc_q[k + 1] + 1) begin
                errors++; $display("FAIL good_latency%0d: got cycle %0d required %0d", k,
                                   obs_out_q[k].cyc, acc_cyc_q[k + 1] + 1);
            end
        end
        checks++;
        if (obs_res_q.size() != 1 || obs_res_q[0].ok !== exp_res_q[0]) begin
            errors++; $display("FAIL good_result: got %0d pulses first ok=%b, required 1 pulse ok=%b",
                               obs_res_q.size(), obs_res_q.size() ? obs_res_q[0].ok : 1'bx, exp_res_q[0]);
        end else begin
            checks++;
            if (obs_res_q[0].cyc != acc_cyc_q[4] + 1) begin
                errors++; $display("FAIL good_done_timing: got cycle %0d required %0d", obs_res_q[0].cyc, acc_cyc_q[4] + 1);
            end
        end
        checks++;
        if (err_count !== exp_err()) begin
            errors++; $display("FAIL good_err_count: got %0d required %0d", err_count, exp_err());
        end
    endtask

    task automatic test_bad_check();
        stim_q.delete();
        add(1, 4'd3); add(0, 4'd1); add(0, 4'd2); add(0, 4'd4); add(0, 4'd6);
        run_stream(100, 0);
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin
            errors++; $display("FAIL bad_out_count: got %0d required %0d", obs_out_q.size(), exp_out_q.size());
        end
        checks++;
        if (obs_res_q.size() != exp_res_q.size()) begin
            errors++; $display("FAIL bad_result_count: got %0d required %0d", obs_res_q.size(), exp_res_q.size());
        end else foreach (exp_res_q[k]) begin
            checks++;
            if (obs_res_q[k].ok !== exp_res_q[k]) begin
                errors++; $display("FAIL bad_result%0d: got ok=%b required %b", k, obs_res_q[k].ok, exp_res_q[k]);
            end
        end
        checks++;
        if (err_count !== exp_err()) begin
            errors++; $display("FAIL bad_err_count: got %0d required %0d", err_count, exp_err());
        end
    endtask

    task automatic test_illegal_len();
        stim_q.delete();
        add(1, 4'd0);
        add(1, 4'd1); add(0, 4'hA); add(0, 4'hA);
        add(1, 4'd3); add(0, 4'd1);
        add(1, 4'd0);
        add(1, 4'd2); add(0, 4'd5); add(0, 4'd6); add(0, 4'd3);
        run_stream(100, 0);
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin
            errors++; $display("FAIL illegal_out_count: got %0d required %0d", obs_out_q.size(), exp_out_q.size());
        end else foreach (exp_out_q[k]) begin
            checks++;
            if ({obs_out_q[k].d, obs_out_q[k].last} !== {exp_out_q[k].d, exp_out_q[k].last}) begin
                errors++; $display("FAIL illegal_beat%0d: got %h/%b required %h/%b", k,
                                   obs_out_q[k].d, obs_out_q[k].last, exp_out_q[k].d, exp_out_q[k].last);
            end
        end
        checks++;
        if (obs_res_q.size() != exp_res_q.size()) begin
            errors++; $display("FAIL illegal_result_count: got %0d required %0d", obs_res_q.size(), exp_res_q.size());
        end else begin
            foreach (exp_res_q[k]) begin
                checks++;
                if (obs_res_q[k].ok !== exp_res_q[k]) begin
                    errors++; $display("FAIL illegal_result%0d: got ok=%b required %b", k, obs_res_q[k].ok, exp_res_q[k]);
                end
            end
            checks++;
            if (obs_res_q[0].cyc != acc_cyc_q[0] + 1) begin
                errors++; $display("FAIL illegal_done_timing: got cycle %0d required %0d", obs_res_q[0].cyc, acc_cyc_q[0] + 1);
            end
            checks++;
            if (obs_res_q[3].cyc != obs_res_q[2].cyc + 1) begin
                errors++; $display("FAIL abort_illegal_pulses: got cycles %0d,%0d required consecutive",
                                   obs_res_q[2].cyc, obs_res_q[3].cyc);
            end
        end
        checks++;
        if (err_count !== exp_err()) begin
            errors++; $display("FAIL illegal_err_count: got %0d required %0d", err_count, exp_err());
        end
    endtask

    task automatic test_abort();
        stim_q.delete();
        add(1, 4'd4); add(0, 4'd3); add(0, 4'd5);
        add(1, 4'd2); add(0, 4'd1); add(0, 4'd1); add(0, 4'd0);
        run_stream(100, 0);
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin
            errors++; $display("FAIL abort_out_count: got %0d required %0d", obs_out_q.size(), exp_out_q.size());
        end else foreach (exp_out_q[k]) begin
            checks++;
            if ({obs_out_q[k].d, obs_out_q[k].last} !== {exp_out_q[k].d, exp_out_q[k].last}) begin
                errors++; $display("FAIL abort_beat%0d: got %h/%b required %h/%b", k,
                                   obs_out_q[k].d, obs_out_q[k].last, exp_out_q[k].d, exp_out_q[k].last);
            end
        end
        checks++;
        if (obs_res_q.size() != exp_res_q.size()) begin
            errors++; $display("FAIL abort_result_count: got %0d required %0d", obs_res_q.size(), exp_res_q.size());
        end else foreach (exp_res_q[k]) begin
            checks++;
            if (obs_res_q[k].ok !== exp_res_q[k]) begin
                errors++; $display("FAIL abort_result%0d: got ok=%b required %b", k, obs_res_q[k].ok, exp_res_q[k]);
            end
        end
        checks++;
        if (err_count !== exp_err()) begin
            errors++; $display("FAIL abort_err_count: got %0d required %0d", err_count, exp_err());
        end
    endtask

    task automatic test_backpressure();
        obs_out_q.delete();
        obs_res_q.delete();
        stim_q.delete();
        add(1, 4'd2); add(0, 4'd9); add(0, 4'd6); add(0, 4'hF);
        @(negedge clk); out_ready = 1'b1; in_valid = 1'b1; in_sof = 1'b1; in_data = 4'd2;
        @(negedge clk); in_sof = 1'b0; in_data = 4'd9;
        @(negedge clk); out_ready = 1'b0; in_data = 4'd6;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_ready%0d: got %b required 0", k, in_ready);
            end
            checks++;
            if ({out_valid, out_data, out_last} !== {1'b1, 4'd9, 1'b0}) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b d=%h l=%b required v=1 d=9 l=0",
                                   k, out_valid, out_data, out_last);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk); in_data = 4'hF;
        drain(6);
        build_expect();
        foreach (exp_res_q[k]) if (!exp_res_q[k]) fails_since_reset++;
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin
            errors++; $display("FAIL bp_out_count: got %0d required %0d", obs_out_q.size(), exp_out_q.size());
        end else foreach (exp_out_q[k]) begin
            checks++;
            if ({obs_out_q[k].d, obs_out_q[k].last} !== {exp_out_q[k].d, exp_out_q[k].last}) begin
                errors++; $display("FAIL bp_beat%0d: got %h/%b required %h/%b", k,
                                   obs_out_q[k].d, obs_out_q[k].last, exp_out_q[k].d, exp_out_q[k].last);
            end
        end
        checks++;
        if (obs_res_q.size() != 1 || obs_res_q[0].ok !== exp_res_q[0]) begin
            errors++; $display("FAIL bp_result: got %0d pulses, required 1 with ok=%b", obs_res_q.size(), exp_res_q[0]);
        end
    endtask

    task automatic test_back_to_back();
        int len;
        bit [DW-1:0] x;
        bit gaps;
        stim_q.delete();
        for (int f = 0; f < 4; f++) begin
            len = $urandom_range(1, MAXL);
            x = '0;
            add(1, DW'(len));
            for (int k = 0; k < len; k++) begin
                add(0, DW'($urandom_range(0, 15)));
                x = x ^ stim_q[stim_q.size() - 1].d;
            end
            add(0, x);
        end
        run_stream(100, 0);
        gaps = 1'b0;
        for (int k = 1; k < acc_cyc_q.size(); k++) if (acc_cyc_q[k] != acc_cyc_q[k - 1] + 1) gaps = 1'b1;
        checks++;
        if (gaps) begin
            errors++; $display("FAIL b2b_throughput: got gaps in %0d accepted beats, required one per cycle", acc_cyc_q.size());
        end
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin
            errors++; $display("FAIL b2b_out_count: got %0d required %0d", obs_out_q.size(), exp_out_q.size());
        end
        checks++;
        if (obs_res_q.size() != exp_res_q.size()) begin
            errors++; $display("FAIL b2b_result_count: got %0d required %0d", obs_res_q.size(), exp_res_q.size());
        end else foreach (exp_res_q[k]) begin
            checks++;
            if (obs_res_q[k].ok !== exp_res_q[k]) begin
                errors++; $display("FAIL b2b_result%0d: got ok=%b required %b", k, obs_res_q[k].ok, exp_res_q[k]);
            end
        end
    endtask

    task automatic test_random();
        int kind;
        int len;
        int cnt;
        bit [DW-1:0] x;
        stim_q.delete();
        for (int f = 0; f < 60; f++) begin
            kind = (f == 59) ? 9 : int'($urandom_range(0, 9));
            len  = $urandom_range(1, MAXL);
            x    = '0;
            case (kind)
                0: add(1, 4'd0);
                1: add(0, DW'($urandom_range(0, 15)));
                2: begin
                    add(1, DW'(len));
                    cnt = $urandom_range(0, len);
                    for (int k = 0; k < cnt; k++) add(0, DW'($urandom_range(0, 15)));
                end
                default: begin
                    add(1, DW'(len));
                    for (int k = 0; k < len; k++) begin
                        add(0, DW'($urandom_range(0, 15)));
                        x = x ^ stim_q[stim_q.size() - 1].d;
                    end
                    if ($urandom_range(99) < 30) x = x ^ DW'($urandom_range(1, 15));
                    add(0, x);
                end
            endcase
        end
        run_stream(70, 20);
        checks++;
        if (obs_out_q.size() != exp_out_q.size()) begin
            errors++; $display("FAIL rand_out_count: got %0d required %0d", obs_out_q.size(), exp_out_q.size());
        end else foreach (exp_out_q[k]) begin
            checks++;
            if ({obs_out_q[k].d, obs_out_q[k].last} !== {exp_out_q[k].d, exp_out_q[k].last}) begin
                errors++; $display("FAIL rand_beat%0d: got %h/%b required %h/%b", k,
                                   obs_out_q[k].d, obs_out_q[k].last, exp_out_q[k].d, exp_out_q[k].last);
            end
        end
        checks++;
        if (obs_res_q.size() != exp_res_q.size()) begin
            errors++; $display("FAIL rand_result_count: got %0d required %0d", obs_res_q.size(), exp_res_q.size());
        end else foreach (exp_res_q[k]) begin
            checks++;
            if (obs_res_q[k].ok !== exp_res_q[k]) begin
                errors++; $display("FAIL rand_result%0d: got ok=%b required %b", k, obs_res_q[k].ok, exp_res_q[k]);
            end
        end
        checks++;
        if (err_count !== exp_err()) begin
            errors++; $display("FAIL rand_err_count: got %0d required %0d", err_count, exp_err());
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_out_q.delete();
        obs_res_q.delete();
        stim_q.delete();
        add(1, 4'd5); add(0, 4'd1); add(0, 4'd2);
        drive_beats(100, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_last, frame_done, frame_ok, err_count} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b v=%b d=%h l=%b done=%b ok=%b err=%0d, required all 0",
                     in_ready, out_valid, out_data, out_last, frame_done, frame_ok, err_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs_res_q.size() != 0) begin
            errors++; $display("FAIL midreset_no_done: got %0d pulses required 0", obs_res_q.size());
        end
        rst_n = 1'b1;
        fails_since_reset = 0;
        stim_q.delete();
        add(1, 4'd1); add(0, 4'hC); add(0, 4'hC);
        run_stream(100, 0);
        checks++;
        if (obs_out_q.size() != 1 || obs_out_q[0].d !== 4'hC || obs_out_q[0].last !== 1'b1) begin
            errors++; $display("FAIL midreset_fresh_beat: got %0d beats, required one C with last", obs_out_q.size());
        end
        checks++;
        if (obs_res_q.size() != exp_res_q.size() || obs_res_q[0].ok !== exp_res_q[0]) begin
            errors++; $display("FAIL midreset_fresh_result: got %0d pulses, required %0d with ok=%b",
                               obs_res_q.size(), exp_res_q.size(), exp_res_q[0]);
        end
        checks++;
        if (err_count !== exp_err()) begin
            errors++; $display("FAIL midreset_err_count: got %0d required %0d", err_count, exp_err());
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_check();
        test_illegal_len();
        test_abort();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
